// File: rtl/rf_writeback_bypass_pkg.sv
// Shared constants and types for the writeback/bypass pipeline.
package rf_writeback_bypass_pkg;

    localparam logic [4:0] XP_REG   = 5'd30;
    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        MEM_EMPTY = 2'd0,
        MEM_READY = 2'd1,
        MEM_WAIT  = 2'd2
    } mem_state_e;

    // valid: data is available for forwarding; werf: stage holds a live regfile writer
    typedef struct packed {
        logic        valid;
        logic [4:0]  wa;
        logic [31:0] data;
        logic        werf;
    } stage_t;

endpackage

// File: rtl/rf_fwd_mux.sv
// Per-operand forwarding mux: picks the youngest matching in-flight result or flags a hazard.
// With RF_BYPASS_EN undefined the regfile value is passed through and any match is a hazard.
module rf_fwd_mux #(
    parameter logic [4:0] ZERO_REG = rf_writeback_bypass_pkg::ZERO_REG
) (
    input  logic [4:0]                      addr,
    input  rf_writeback_bypass_pkg::stage_t ex_stage,
    input  rf_writeback_bypass_pkg::stage_t mem_stage,
    input  rf_writeback_bypass_pkg::stage_t wb_stage,
    input  logic [31:0]                     rf_data,
    output logic [31:0]                     operand,
    output logic                            hazard
);
    import rf_writeback_bypass_pkg::*;

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign ex_hit  = ex_stage.werf  && (ex_stage.wa  == addr);
    assign mem_hit = mem_stage.werf && (mem_stage.wa == addr);
    assign wb_hit  = wb_stage.werf  && (wb_stage.wa  == addr);

`ifdef RF_BYPASS_EN
    logic unused_wb_valid;
    assign unused_wb_valid = wb_stage.valid;

    // Youngest stage wins; a matching stage without data yet stalls decode
    always_comb begin
        operand = rf_data;
        hazard  = 1'b0;
        if (addr == ZERO_REG) begin
            operand = '0;
        end else if (ex_hit) begin
            if (ex_stage.valid) operand = ex_stage.data;
            else                hazard  = 1'b1;
        end else if (mem_hit) begin
            if (mem_stage.valid) operand = mem_stage.data;
            else                 hazard  = 1'b1;
        end else if (wb_hit) begin
            operand = wb_stage.data;
        end
    end
`else
    logic unused_stage_bits;
    assign unused_stage_bits = ^{ex_stage.valid, ex_stage.data, mem_stage.valid,
                                 mem_stage.data, wb_stage.valid, wb_stage.data};

    always_comb begin
        operand = rf_data;
        hazard  = 1'b0;
        if (addr == ZERO_REG) begin
            operand = '0;
        end else begin
            hazard = ex_hit || mem_hit || wb_hit;
        end
    end
`endif

endmodule

// File: rtl/rf_writeback_bypass.sv
// Writeback/bypass pipeline: MEM and WB result registers, regfile write port and operand forwarding.
// Define RF_BYPASS_EN to forward in-flight results; otherwise decode stalls until the regfile holds them.
module rf_writeback_bypass #(
    parameter logic [4:0] XP_REG   = rf_writeback_bypass_pkg::XP_REG,
    parameter logic [4:0] ZERO_REG = rf_writeback_bypass_pkg::ZERO_REG
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rc,
    input  logic        ex_wasel,
    input  logic        ex_werf,
    input  logic        ex_load,
    input  logic [31:0] ex_result,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    input  logic [4:0]  dec_ra,
    input  logic [4:0]  dec_rb,
    input  logic [31:0] rf_radata,
    input  logic [31:0] rf_rbdata,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        dec_stall,
    output logic        pipe_stall,
    output logic [31:0] wb_wdata,
    output logic [4:0]  wb_wa,
    output logic        wb_werf
);
    import rf_writeback_bypass_pkg::*;

    mem_state_e  mem_state;
    logic [4:0]  mem_wa;
    logic [31:0] mem_data;
    logic        mem_werf;

    logic [4:0]  ex_wa;
    logic        ex_live;
    logic        ex_is_load;
    logic        ex_rvalid;
    logic        stall_mem;

    stage_t      ex_rec;
    stage_t      mem_rec;
    stage_t      wb_rec;

    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic        haz_a;
    logic        haz_b;

    assign ex_wa      = ex_wasel ? XP_REG : ex_rc;
    assign ex_live    = ex_valid && ex_werf && (ex_wa != ZERO_REG);
    assign ex_is_load = ex_load && ex_live;
    // rvalid belongs to the waiting MEM load first; only otherwise can EX capture it
    assign ex_rvalid  = mem_rvalid && (mem_state != MEM_WAIT);
    assign stall_mem  = (mem_state == MEM_WAIT) && !mem_rvalid;

    // MEM slot: holds while waiting on load data, otherwise takes whatever EX presents
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_state <= MEM_EMPTY;
            mem_wa    <= '0;
            mem_data  <= '0;
            mem_werf  <= 1'b0;
        end else if (!stall_mem) begin
            mem_wa   <= ex_wa;
            mem_werf <= ex_live;
            mem_data <= ex_is_load ? mem_rdata : ex_result;
            if (!ex_valid) begin
                mem_state <= MEM_EMPTY;
            end else if (ex_is_load && !ex_rvalid) begin
                mem_state <= MEM_WAIT;
            end else begin
                mem_state <= MEM_READY;
            end
        end
    end

    // WB takes a bubble while frozen; a waiting load retires with the arriving mem_rdata
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_werf  <= 1'b0;
            wb_wa    <= '0;
            wb_wdata <= '0;
        end else if (stall_mem) begin
            wb_werf <= 1'b0;
        end else begin
            wb_werf <= mem_werf && (mem_state != MEM_EMPTY);
            if (mem_state != MEM_EMPTY) begin
                wb_wa    <= mem_wa;
                wb_wdata <= (mem_state == MEM_WAIT) ? mem_rdata : mem_data;
            end
        end
    end

    assign ex_rec  = '{valid: !ex_load, wa: ex_wa, data: ex_result, werf: ex_live};
    assign mem_rec = '{valid: (mem_state == MEM_READY), wa: mem_wa, data: mem_data,
                       werf: mem_werf && (mem_state != MEM_EMPTY)};
    assign wb_rec  = '{valid: 1'b1, wa: wb_wa, data: wb_wdata, werf: wb_werf};

    rf_fwd_mux #(.ZERO_REG(ZERO_REG)) u_fwd_a (
        .addr      (dec_ra),
        .ex_stage  (ex_rec),
        .mem_stage (mem_rec),
        .wb_stage  (wb_rec),
        .rf_data   (rf_radata),
        .operand   (fwd_a),
        .hazard    (haz_a)
    );

    rf_fwd_mux #(.ZERO_REG(ZERO_REG)) u_fwd_b (
        .addr      (dec_rb),
        .ex_stage  (ex_rec),
        .mem_stage (mem_rec),
        .wb_stage  (wb_rec),
        .rf_data   (rf_rbdata),
        .operand   (fwd_b),
        .hazard    (haz_b)
    );

    assign op_a       = reset_n ? fwd_a : '0;
    assign op_b       = reset_n ? fwd_b : '0;
    assign dec_stall  = reset_n && (haz_a || haz_b);
    assign pipe_stall = reset_n && stall_mem;

endmodule

// File: tb/tb_rf_writeback_bypass.sv
// Bench for rf_writeback_bypass: directed vector table, reset-during-load sequence, random vs model.
// Expectations follow RF_BYPASS_EN the same way the design does.
module tb_rf_writeback_bypass;

    localparam logic [31:0] RFA = 32'hA0A0_A0A0;
    localparam logic [31:0] RFB = 32'hB0B0_B0B0;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ex_valid, ex_wasel, ex_werf, ex_load, mem_rvalid;
    logic [4:0]  ex_rc, dec_ra, dec_rb;
    logic [31:0] ex_result, mem_rdata, rf_radata, rf_rbdata;
    logic [31:0] op_a, op_b, wb_wdata;
    logic        dec_stall, pipe_stall, wb_werf;
    logic [4:0]  wb_wa;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ex_valid;
        logic [4:0]  rc;
        logic        wasel, werf, load;
        logic [31:0] result;
        logic        rvalid;
        logic [31:0] rdata;
        logic [4:0]  ra, rb;
        logic [31:0] rfa, rfb;
        logic [31:0] exp_a, exp_b;
        logic        exp_ds, exp_ps, exp_we;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd;
    } vec_t;

    // In-flight picture for the reference model: what sits after EX, and what sits in writeback
    bit          m_occ, m_wait, m_wr;
    logic [4:0]  m_wa;
    logic [31:0] m_data;
    bit          w_wr;
    logic [4:0]  w_wa;
    logic [31:0] w_data;

    always #5 clock = ~clock;

    rf_writeback_bypass dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ex_valid   (ex_valid),
        .ex_rc      (ex_rc),
        .ex_wasel   (ex_wasel),
        .ex_werf    (ex_werf),
        .ex_load    (ex_load),
        .ex_result  (ex_result),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .dec_ra     (dec_ra),
        .dec_rb     (dec_rb),
        .rf_radata  (rf_radata),
        .rf_rbdata  (rf_rbdata),
        .op_a       (op_a),
        .op_b       (op_b),
        .dec_stall  (dec_stall),
        .pipe_stall (pipe_stall),
        .wb_wdata   (wb_wdata),
        .wb_wa      (wb_wa),
        .wb_werf    (wb_werf)
    );

    function automatic vec_t row(input logic v, input logic [4:0] rc, input logic wasel, werf, load,
                                 input logic [31:0] res, input logic rv, input logic [31:0] rd,
                                 input logic [4:0] ra, rb,
                                 input logic [31:0] a_byp, b_byp, input logic ds_byp,
                                 input logic [31:0] a_nb, b_nb, input logic ds_nb,
                                 input logic ps, we, input logic [4:0] wa, input logic [31:0] wd);
        vec_t r;
        r.ex_valid = v;  r.rc = rc;  r.wasel = wasel;  r.werf = werf;  r.load = load;
        r.result = res;  r.rvalid = rv;  r.rdata = rd;  r.ra = ra;  r.rb = rb;
        r.rfa = RFA;  r.rfb = RFB;
`ifdef RF_BYPASS_EN
        r.exp_a = a_byp;  r.exp_b = b_byp;  r.exp_ds = ds_byp;
`else
        r.exp_a = a_nb;   r.exp_b = b_nb;   r.exp_ds = ds_nb;
`endif
        r.exp_ps = ps;  r.exp_we = we;  r.exp_wa = wa;  r.exp_wd = wd;
        return r;
    endfunction

    function automatic logic [4:0] exWa(input vec_t v);
        return v.wasel ? 5'd30 : v.rc;
    endfunction

    function automatic bit exLive(input vec_t v);
        return v.ex_valid && v.werf && (exWa(v) != 5'd31);
    endfunction

    // Search the in-flight writers youngest first for the register decode wants
    function automatic void fwd(input logic [4:0] addr, input logic [31:0] rf, input vec_t v,
                                output logic [31:0] op, output logic st);
        bit          wr[3];
        logic [4:0]  wa[3];
        bit          rdy[3];
        logic [31:0] dat[3];
        bit          found = 0;
        wr[0] = exLive(v);     wa[0] = exWa(v); rdy[0] = !v.load; dat[0] = v.result;
        wr[1] = m_occ && m_wr; wa[1] = m_wa;    rdy[1] = !m_wait; dat[1] = m_data;
        wr[2] = w_wr;          wa[2] = w_wa;    rdy[2] = 1'b1;    dat[2] = w_data;
        op = rf;
        st = 1'b0;
        if (addr == 5'd31) begin
            op = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!found && wr[i] && wa[i] == addr) begin
                    found = 1;
`ifdef RF_BYPASS_EN
                    if (rdy[i]) op = dat[i];
                    else        st = 1'b1;
`else
                    st = 1'b1;
`endif
                end
            end
        end
    endfunction

    function automatic vec_t predict(input vec_t v);
        vec_t  r = v;
        logic  sa, sb;
        fwd(v.ra, v.rfa, v, r.exp_a, sa);
        fwd(v.rb, v.rfb, v, r.exp_b, sb);
        r.exp_ds = sa || sb;
        r.exp_ps = m_occ && m_wait && !v.rvalid;
        r.exp_we = w_wr;
        r.exp_wa = w_wa;
        r.exp_wd = w_data;
        return r;
    endfunction

    task automatic modelReset();
        m_occ = 0; m_wait = 0; m_wr = 0; m_wa = '0; m_data = '0;
        w_wr = 0;  w_wa = '0;  w_data = '0;
    endtask

    // One clock edge of the model: a waiting load freezes MEM, else everything moves one slot on
    task automatic modelStep(input vec_t v);
        bit old_wait = m_occ && m_wait;
        bit live     = exLive(v);
        if (old_wait && !v.rvalid) begin
            w_wr = 0;
        end else begin
            w_wr   = m_occ && m_wr;
            w_wa   = m_wa;
            w_data = old_wait ? v.rdata : m_data;
            m_occ  = v.ex_valid;
            m_wr   = live;
            m_wa   = exWa(v);
            m_wait = v.load && live && !(v.rvalid && !old_wait);
            m_data = (v.load && live) ? v.rdata : v.result;
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        ex_valid   = v.ex_valid;  ex_rc = v.rc;  ex_wasel = v.wasel;  ex_werf = v.werf;
        ex_load    = v.load;      ex_result = v.result;
        mem_rvalid = v.rvalid;    mem_rdata = v.rdata;
        dec_ra     = v.ra;        dec_rb = v.rb;
        rf_radata  = v.rfa;       rf_rbdata = v.rfb;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        #1;
        checkVal($sformatf("pipe_stall[%0d]", idx), pipe_stall, v.exp_ps);
        checkVal($sformatf("dec_stall[%0d]", idx), dec_stall, v.exp_ds);
        checkVal($sformatf("wb_werf[%0d]", idx), wb_werf, v.exp_we);
        if (!v.exp_ds) begin
            checkVal($sformatf("op_a[%0d]", idx), op_a, v.exp_a);
            checkVal($sformatf("op_b[%0d]", idx), op_b, v.exp_b);
        end
        if (v.exp_we) begin
            checkVal($sformatf("wb_wa[%0d]", idx), wb_wa, v.exp_wa);
            checkVal($sformatf("wb_wdata[%0d]", idx), wb_wdata, v.exp_wd);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, ".op_a"}, op_a, 32'h0);
        checkVal({tag, ".op_b"}, op_b, 32'h0);
        checkVal({tag, ".dec_stall"}, dec_stall, 32'h0);
        checkVal({tag, ".pipe_stall"}, pipe_stall, 32'h0);
        checkVal({tag, ".wb_werf"}, wb_werf, 32'h0);
        checkVal({tag, ".wb_wa"}, wb_wa, 32'h0);
        checkVal({tag, ".wb_wdata"}, wb_wdata, 32'h0);
    endtask

    function automatic logic [4:0] pickReg();
        case ($urandom_range(0, 6))
            0: return 5'd1;
            1: return 5'd2;
            2: return 5'd7;
            3: return 5'd30;
            4: return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    vec_t tbl[25];
    vec_t v;

    initial begin
        // Fields: v rc wasel werf load result | rvalid rdata | ra rb | bypass a b ds | plain a b ds | ps we wa wd
        tbl[0]  = row(1, 1, 0,1,0, 32'h1,    0, 0,       1, 5,  32'h1, RFB, 0,      RFA, RFB, 1,  0,0,0,0);
        tbl[1]  = row(1, 5, 0,1,0, 32'h2,    0, 0,       1, 5,  32'h1, 32'h2, 0,    RFA, RFB, 1,  0,0,0,0);
        tbl[2]  = row(1, 5, 0,1,0, 32'h3,    0, 0,       1, 5,  32'h1, 32'h3, 0,    RFA, RFB, 1,  0,1,1,32'h1);
        tbl[3]  = row(1, 31,0,1,0, 32'h9,    0, 0,      31, 5,  0, 32'h3, 0,        0, RFB, 1,    0,1,5,32'h2);
        tbl[4]  = row(1, 7, 1,1,0, 32'h77,   0, 0,       7, 31, RFA, 0, 0,          RFA, 0, 0,    0,1,5,32'h3);
        tbl[5]  = row(0, 0, 0,0,0, 0,        0, 0,      30, 7,  32'h77, RFB, 0,     RFA, RFB, 1,  0,0,0,0);
        tbl[6]  = row(1, 4, 0,1,1, 32'h1111, 0, 0,      30, 4,  0, 0, 1,            0, 0, 1,      0,1,30,32'h77);
        tbl[7]  = row(0, 0, 0,0,0, 0,        0, 0,       0, 4,  0, 0, 1,            0, 0, 1,      1,0,0,0);
        tbl[8]  = row(1, 9, 0,1,0, 32'h99,   0, 0,       0, 4,  0, 0, 1,            0, 0, 1,      1,0,0,0);
        tbl[9]  = row(0, 0, 0,0,0, 0,        0, 0,       0, 4,  0, 0, 1,            0, 0, 1,      1,0,0,0);
        tbl[10] = row(0, 0, 0,0,0, 0,        1, 32'hDEAD, 0, 4, 0, 0, 1,            0, 0, 1,      0,0,0,0);
        tbl[11] = row(0, 0, 0,0,0, 0,        0, 0,       0, 4,  RFA, 32'hDEAD, 0,   RFA, RFB, 1,  0,1,4,32'hDEAD);
        tbl[12] = row(0, 0, 0,0,0, 0,        0, 0,       0, 4,  RFA, RFB, 0,        RFA, RFB, 0,  0,0,0,0);
        tbl[13] = row(1, 2, 0,1,0, 32'h22,   0, 0,       2, 0,  32'h22, RFB, 0,     RFA, RFB, 1,  0,0,0,0);
        tbl[14] = row(0, 0, 0,0,0, 0,        0, 0,       2, 0,  32'h22, RFB, 0,     RFA, RFB, 1,  0,0,0,0);
        tbl[15] = row(0, 0, 0,0,0, 0,        0, 0,       2, 0,  32'h22, RFB, 0,     RFA, RFB, 1,  0,1,2,32'h22);
        tbl[16] = row(0, 0, 0,0,0, 0,        0, 0,       2, 0,  RFA, RFB, 0,        RFA, RFB, 0,  0,0,0,0);
        tbl[17] = row(1, 3, 0,1,1, 32'h1234, 1, 32'h3333, 3, 0, 0, 0, 1,            0, 0, 1,      0,0,0,0);
        tbl[18] = row(0, 0, 0,0,0, 0,        0, 0,       3, 0,  32'h3333, RFB, 0,   RFA, RFB, 1,  0,0,0,0);
        tbl[19] = row(0, 0, 0,0,0, 0,        0, 0,       3, 0,  32'h3333, RFB, 0,   RFA, RFB, 1,  0,1,3,32'h3333);
        tbl[20] = row(0, 0, 0,0,0, 0,        1, 32'h5A,  3, 0,  RFA, RFB, 0,        RFA, RFB, 0,  0,0,0,0);
        // Reset-during-load sequence rows
        tbl[21] = row(1, 6, 0,1,1, 32'h6,    0, 0,       6, 0,  0, 0, 1,            0, 0, 1,      0,0,0,0);
        tbl[22] = row(0, 0, 0,0,0, 0,        0, 0,       6, 0,  0, 0, 1,            0, 0, 1,      1,0,0,0);
        tbl[23] = row(0, 0, 0,0,0, 0,        1, 32'h55,  0, 0,  RFA, RFB, 0,        RFA, RFB, 0,  0,0,0,0);
        tbl[24] = row(0, 0, 0,0,0, 0,        0, 0,       6, 0,  RFA, RFB, 0,        RFA, RFB, 0,  0,0,0,0);

        reset_n = 1'b0;
        ex_valid = 0; ex_rc = 0; ex_wasel = 0; ex_werf = 0; ex_load = 0; ex_result = 0;
        mem_rvalid = 0; mem_rdata = 0; dec_ra = 5'd1; dec_rb = 5'd2;
        rf_radata = RFA; rf_rbdata = RFB;
        #1;
        checkAllZero("reset");
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i <= 20; i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i], i);
        end

        // Reset arrives while a load to R6 is still waiting; a late rvalid must not write anything
        applyStimulus(tbl[21]);
        checkOutput(tbl[21], 21);
        applyStimulus(tbl[22]);
        checkOutput(tbl[22], 22);
        #1;
        reset_n = 1'b0;
        dec_ra  = 5'd1;
        dec_rb  = 5'd2;
        #1;
        checkAllZero("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(tbl[23]);
        checkOutput(tbl[23], 23);
        applyStimulus(tbl[24]);
        checkOutput(tbl[24], 24);
        applyStimulus(tbl[24]);
        checkOutput(tbl[24], 25);

        @(negedge clock);
        reset_n = 1'b0;
        ex_valid = 0;
        mem_rvalid = 0;
        @(negedge clock);
        reset_n = 1'b1;
        modelReset();

        for (int n = 0; n < 400; n++) begin
            v.ex_valid = ($urandom_range(0, 3) != 0);
            v.rc       = pickReg();
            v.wasel    = ($urandom_range(0, 5) == 0);
            v.werf     = ($urandom_range(0, 4) != 0);
            v.load     = ($urandom_range(0, 3) == 0);
            v.result   = $urandom;
            v.rvalid   = ($urandom_range(0, 2) == 0);
            v.rdata    = $urandom;
            v.ra       = pickReg();
            v.rb       = pickReg();
            v.rfa      = $urandom;
            v.rfb      = $urandom;
            v = predict(v);
            applyStimulus(v);
            checkOutput(v, 1000 + n);
            @(posedge clock);
            modelStep(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
